// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see mem_arb_pick).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned CNT_W   = 4;

  // Out-of-range latencies are clamped so the counter always fits CNT_W bits.
  function automatic logic [CNT_W-1:0] cnt_init(input int unsigned lat);
    int unsigned l;
    l = (lat < LAT_MIN) ? LAT_MIN : ((lat > LAT_MAX) ? LAT_MAX : lat);
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IF and D requesters.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise fixed D-over-IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  owner_e last_owner_i,
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  always_comb begin
    grant_valid_o = if_req_i | d_req_i;
    grant_owner_o = OWN_IF;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req_i && d_req_i) begin
      grant_owner_o = (last_owner_i == OWN_D) ? OWN_IF : OWN_D;
    end else if (d_req_i) begin
      grant_owner_o = OWN_D;
    end
`else
    if (d_req_i) begin
      grant_owner_o = OWN_D;
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = (last_owner_i == OWN_D);
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and D requesters onto one single-ported memory with fixed latency.
// Optional ARB_ROUND_ROBIN_EN adds a last_owner register for fair contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = cnt_init(LATENCY);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic   grant_valid;
  owner_e grant_owner;
  owner_e last_owner;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_q, last_owner_d;

  always_ff @(posedge clk) begin
    if (reset) last_owner_q <= OWN_IF;
    else       last_owner_q <= last_owner_d;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == ST_IDLE && grant_valid) last_owner_d = grant_owner;
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_req_i      (if_req),
    .d_req_i       (d_req),
    .last_owner_i  (last_owner),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          cnt_d   = CNT_INIT;
          state_d = ST_ACCESS;
          if (grant_owner == OWN_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d = if_addr;
            we_d   = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    if (state_q == ST_ACCESS) begin
      mem_re = ~we_q;
      mem_we = we_q;
    end
    if (state_q == ST_DONE) begin
      if_ready = (owner_q == OWN_IF);
      d_ready  = (owner_q == OWN_D);
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; honours ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  exp_t q_if[$];
  exp_t q_d[$];
  logic model_last = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    if (a == 32'h104) return 32'h00A00113;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata = rom(mem_addr);

  // Expected winner given the request levels the DUT will see in IDLE (1 = D).
  function automatic logic pick(input logic i, input logic d);
`ifdef ARB_ROUND_ROBIN_EN
    if (i && d) return ~model_last;
`endif
    return d;
  endfunction

  task automatic issue_if(input logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
    q_if.push_back('{a, 1'b0, 32'h0, rom(a)});
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    q_d.push_back('{a, we, wd, we ? 32'h0 : rom(a)});
  endtask

  task automatic wait_ready(input logic [31:0] ea, input logic [31:0] ew,
                            output int cyc, output int re_n, output int we_n,
                            output int bad, output logic s_if, output logic s_d);
    cyc = -1; re_n = 0; we_n = 0; bad = 0; s_if = 1'b0; s_d = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (mem_we) we_n++;
      if ((mem_re || mem_we) && (mem_addr !== ea || (mem_we && mem_wdata !== ew))) bad++;
      if (if_ready || d_ready) begin
        s_if = if_ready;
        s_d = d_ready;
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_re, mem_we}); end
    checks++; if ({if_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {if_ready, d_ready}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", if_rdata); end
    reset = 1'b0;
    model_last = 1'b0;
  endtask

  task automatic test_if_read();
    exp_t e; int cyc, re_n, we_n, bad; logic s_if, s_d;
    q_if.delete(); q_d.delete();
    @(negedge clk);
    issue_if(32'h100);
    e = q_if[0];
    wait_ready(e.addr, e.wdata, cyc, re_n, we_n, bad, s_if, s_d);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL if_latency: got %0d expected %0d", cyc, LAT + 1); end
    checks++; if (re_n !== LAT) begin errors++; $display("FAIL if_re_cycles: got %0d expected %0d", re_n, LAT); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL if_we_cycles: got %0d expected 0", we_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL if_mem_addr: %0d bad cycles expected 0", bad); end
    checks++; if ({s_if, s_d} !== 2'b10) begin errors++; $display("FAIL if_ready_owner: got %b expected 10", {s_if, s_d}); end
    if (s_if) begin
      e = q_if.pop_front();
      model_last = 1'b0;
      checks++; if (if_rdata !== e.rdata) begin errors++; $display("FAIL if_rdata: got %h expected %h", if_rdata, e.rdata); end
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, d_ready, busy} !== 3'b000) begin errors++; $display("FAIL if_after: got %b expected 000", {if_ready, d_ready, busy}); end
  endtask

  task automatic test_store();
    exp_t e; int cyc, re_n, we_n, bad; logic s_if, s_d;
    q_if.delete(); q_d.delete();
    @(negedge clk);
    issue_d(1'b1, 32'h200, 32'hDEADBEEF);
    e = q_d[0];
    wait_ready(e.addr, e.wdata, cyc, re_n, we_n, bad, s_if, s_d);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL st_latency: got %0d expected %0d", cyc, LAT + 1); end
    checks++; if (we_n !== LAT) begin errors++; $display("FAIL st_we_cycles: got %0d expected %0d", we_n, LAT); end
    checks++; if (re_n !== 0) begin errors++; $display("FAIL st_re_cycles: got %0d expected 0", re_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL st_addr_wdata: %0d bad cycles expected 0", bad); end
    checks++; if ({s_if, s_d} !== 2'b01) begin errors++; $display("FAIL st_ready_owner: got %b expected 01", {s_if, s_d}); end
    if (s_d) begin
      void'(q_d.pop_front());
      model_last = 1'b1;
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, d_ready, busy} !== 3'b000) begin errors++; $display("FAIL st_after: got %b expected 000", {if_ready, d_ready, busy}); end
  endtask

  // Both request at once; with hold=1 the first winner re-requests at its ready.
  task automatic test_simultaneous(input logic hold);
    exp_t e; int cyc, re_n, we_n, bad; logic s_if, s_d, w;
    q_if.delete(); q_d.delete();
    @(negedge clk);
    issue_if(32'h0);
    issue_d(1'b0, 32'h80, 32'h0);
    for (int k = 0; k < 4 && (q_if.size() + q_d.size()) > 0; k++) begin
      w = pick(if_req, d_req);
      e = w ? q_d[0] : q_if[0];
      wait_ready(e.addr, e.wdata, cyc, re_n, we_n, bad, s_if, s_d);
      checks++; if (cyc !== ((k == 0) ? LAT + 1 : LAT + 2)) begin errors++; $display("FAIL sim_latency[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? LAT + 1 : LAT + 2); end
      checks++; if ({s_if, s_d} !== {~w, w}) begin errors++; $display("FAIL sim_winner[%0d]: got %b expected %b", k, {s_if, s_d}, {~w, w}); end
      checks++; if (re_n !== LAT || bad !== 0) begin errors++; $display("FAIL sim_access[%0d]: re=%0d bad=%0d expected re=%0d bad=0", k, re_n, bad, LAT); end
      if (cyc < 0) break;
      if (s_d) begin
        e = q_d.pop_front();
        checks++; if (d_rdata !== e.rdata) begin errors++; $display("FAIL sim_d_rdata[%0d]: got %h expected %h", k, d_rdata, e.rdata); end
      end else begin
        e = q_if.pop_front();
        checks++; if (if_rdata !== e.rdata) begin errors++; $display("FAIL sim_if_rdata[%0d]: got %h expected %h", k, if_rdata, e.rdata); end
      end
      model_last = s_d;
      if (s_d) d_req = 1'b0; else if_req = 1'b0;
      if (hold && k == 0) begin
        if (s_d) issue_d(1'b0, 32'h84, 32'h0);
        else issue_if(32'h104);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, d_ready, busy} !== 3'b000) begin errors++; $display("FAIL sim_after: got %b expected 000", {if_ready, d_ready, busy}); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int cyc, re_n, we_n, bad; logic s_if, s_d;
    q_if.delete(); q_d.delete();
    @(negedge clk);
    issue_if(32'h100);
    for (int k = 0; k < 2; k++) begin
      e = q_if[0];
      wait_ready(e.addr, e.wdata, cyc, re_n, we_n, bad, s_if, s_d);
      checks++; if (cyc !== ((k == 0) ? LAT + 1 : LAT + 2)) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? LAT + 1 : LAT + 2); end
      checks++; if (bad !== 0 || re_n !== LAT) begin errors++; $display("FAIL b2b_access[%0d]: re=%0d bad=%0d expected re=%0d bad=0", k, re_n, bad, LAT); end
      if (!s_if) break;
      e = q_if.pop_front();
      model_last = 1'b0;
      checks++; if (if_rdata !== e.rdata) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, if_rdata, e.rdata); end
      if (k == 0) issue_if(32'h104);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, d_ready, busy} !== 3'b000) begin errors++; $display("FAIL b2b_after: got %b expected 000", {if_ready, d_ready, busy}); end
  endtask

  task automatic test_reset_mid();
    int readies;
    q_if.delete(); q_d.delete();
    @(negedge clk);
    issue_d(1'b1, 32'h40, 32'h12345678);
    repeat (2) @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL rm_access: we=%b addr=%h expected we=1 addr=00000040", mem_we, mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    model_last = 1'b0;
    q_d.delete();
    checks++; if ({mem_we, mem_re, busy} !== 3'b000) begin errors++; $display("FAIL rm_abort: we/re/busy got %b expected 000", {mem_we, mem_re, busy}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h expected 0", mem_addr); end
    readies = 0;
    for (int n = 0; n < 2 * LAT + 2; n++) begin
      if (if_ready || d_ready || busy) readies++;
      @(negedge clk);
    end
    checks++; if (readies !== 0) begin errors++; $display("FAIL rm_no_ready: got %0d active cycles expected 0", readies); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_if_read();
    test_store();
    test_simultaneous(1'b0);
    test_simultaneous(1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
